serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder cell reused LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             cout_r;
    logic             fa_s;
    logic             fa_c;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as a + ~b + 1; cin is ignored in that mode
    assign b_cap = sub ? ~b : b;
    assign c_cap = sub | cin;
`else
    assign b_cap = b;
    assign c_cap = cin;
`endif

    // The single shared full-adder cell
    assign fa_s = opa[0] ^ opb[0] ^ carry;
    assign fa_c = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));

    assign sum  = res;
    assign cout = cout_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, serial shift and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= fa_c;
            res   <= {fa_s, res[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            if (last) cout_r <= fa_c;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the serial adder
// against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full (W+1)-bit result of the requested operation
    function automatic logic [W:0] model(input logic [W-1:0] xa,
                                         input logic [W-1:0] xb,
                                         input logic xc,
                                         input logic xs);
        int unsigned r;
        if (xs) r = int'(xa) + int'((~xb) & 8'hFF) + 1;
        else    r = int'(xa) + int'(xb) + int'(xc);
        return (W+1)'(r);
    endfunction

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input logic xs, input string tag);
        logic [W:0] exp;
        int nbusy;
        int ndone;
        exp = model(xa, xb, xc, xs);
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        sub = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < W; i++) begin
            nbusy += int'(busy);
            ndone += int'(done);
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
        chk({tag, "_early_done"}, 32'(ndone), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(exp[W]));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(exp[W-1:0]));
    endtask

    logic [W-1:0] oa [0:44];
    logic [W-1:0] ob [0:44];
    logic         oc [0:44];

    initial begin
        logic [W:0] exp;
        int ndone;
        logic [W-1:0] seen;

        // Reset state, before any clock edge
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed additions
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "a5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "ff_ff_c");
        run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");

        // Random additions
        for (int i = 0; i < 10; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
        run_op(8'h01, 8'h02, 1'b1, 1'b1, "sub_01_02");
`endif

        // Start during RUN is dropped
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        seen = '0;
        for (int i = 0; i < 13; i++) begin
            if (done) begin
                ndone++;
                seen = sum;
            end
            @(negedge clk);
        end
        chk("drop_done_count", 32'(ndone), 32'd1);
        chk("drop_sum", 32'(seen), 32'h33);
        chk("drop_idle", 32'(busy), 32'd0);

        // Start held high: accept every W+1 cycles
        start = 1'b1;
        for (int n = 0; n < 45; n++) begin
            oa[n] = W'($urandom);
            ob[n] = W'($urandom);
            oc[n] = 1'($urandom);
            a = oa[n]; b = ob[n]; cin = oc[n];
            @(posedge clk);
            @(negedge clk);
            chk("b2b_done", 32'(done), 32'((n % (W + 1)) == W));
            if ((n % (W + 1)) == W) begin
                exp = model(oa[n-W], ob[n-W], oc[n-W], 1'b0);
                chk("b2b_sum", 32'(sum), 32'(exp[W-1:0]));
                chk("b2b_cout", 32'(cout), 32'(exp[W]));
            end
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset in mid-operation
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            ndone += int'(done);
            @(negedge clk);
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
